// File: rtl/sm_fv_bank_fill_serve.sv
`default_nettype none
// ============================================================================
// Module   : sm_fv_bank_fill_serve
// Purpose  : Small feature-value bank sitting behind the FV bank controller.
//            Captures one sos/eos framed stream of addressed lines into a
//            local register-array cache, then serves per-node multi-line
//            bursts (sos/eos framed, tagged with the requesting Edge PE).
//            An incoming stream always wins over an in-flight burst.
// Ports    : clk, reset (sync, active-low)
//            in_sos/in_eos/in_A/in_data          - fill stream
//            rd_req_valid/rd_req_ready/rd_node/rd_len/rd_tag - read request
//            out_valid/out_sos/out_eos/out_data/out_tag      - burst output
//            fill_done, cache_valid, err_abort   - status
// Revision : 1.0 - initial release
// ============================================================================
module sm_fv_bank_fill_serve #(
    parameter int FV_BW          = 128,
    parameter int ADDR_W         = 6,
    parameter int LINES_PER_NODE = 8,
    parameter int NODE_W         = 3,
    parameter int PE_TAG_W       = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_sos,
    input  logic                              in_eos,
    input  logic [ADDR_W-1:0]                 in_A,
    input  logic [FV_BW-1:0]                  in_data,
    input  logic                              rd_req_valid,
    output logic                              rd_req_ready,
    input  logic [NODE_W-1:0]                 rd_node,
    input  logic [$clog2(LINES_PER_NODE):0]   rd_len,
    input  logic [PE_TAG_W-1:0]               rd_tag,
    output logic                              out_valid,
    output logic                              out_sos,
    output logic                              out_eos,
    output logic [FV_BW-1:0]                  out_data,
    output logic [PE_TAG_W-1:0]               out_tag,
    output logic                              fill_done,
    output logic                              cache_valid,
    output logic                              err_abort
);

    localparam int c_DEPTH = 2**ADDR_W;
    localparam int c_OFF_W = $clog2(LINES_PER_NODE);
    localparam int c_LEN_W = c_OFF_W + 1;
    localparam logic [c_LEN_W-1:0] c_LPN = c_LEN_W'(LINES_PER_NODE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_READY = 2'd2,
        S_SERVE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [FV_BW-1:0]       r_mem [c_DEPTH];

    logic [ADDR_W-1:0]      r_base;
    logic [c_LEN_W-1:0]     r_len;
    // Index of the next line to load into the output registers.
    logic [c_LEN_W-1:0]     r_cnt;
    logic [PE_TAG_W-1:0]    r_tag;

    logic                   r_out_valid;
    logic                   r_out_sos;
    logic                   r_out_eos;
    logic [FV_BW-1:0]       r_out_data;
    logic                   r_fill_done;
    logic                   r_cache_valid;
    logic                   r_err_abort;

    logic                   w_beat;
    logic                   w_ready;
    logic                   w_accept;
    logic [ADDR_W-1:0]      w_req_base;
    logic [c_LEN_W-1:0]     w_req_len;
    logic                   w_load;
    logic                   w_last;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic                   w_fill_end;

    // Beats are not captured while reset is asserted.
    assign w_beat     = reset & (in_sos | (r_state == S_FILL));
    assign w_ready    = (r_state == S_READY) & ~in_sos;
    assign w_accept   = rd_req_valid & w_ready;
    // node * LINES_PER_NODE as a shift; upper node bits alias by wrap.
    assign w_req_base = ADDR_W'(rd_node) << c_OFF_W;
    assign w_req_len  = ((rd_len == '0) || (rd_len > c_LPN)) ? c_LPN : rd_len;
    assign w_fill_end = in_eos & (in_sos | (r_state == S_FILL));

    // The state returns to READY on the same edge the eos beat is loaded, so a
    // follow-on request can be accepted while that eos beat is on the outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        w_rd_addr   = r_base + ADDR_W'(r_cnt);
        if (in_sos) begin
            w_state_nxt = in_eos ? S_READY : S_FILL;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (in_eos) begin
                        w_state_nxt = S_READY;
                    end
                end
                S_READY: begin
                    if (w_accept) begin
                        w_load      = 1'b1;
                        w_rd_addr   = w_req_base;
                        w_last      = (w_req_len == c_LEN_W'(1));
                        w_state_nxt = w_last ? S_READY : S_SERVE;
                    end
                end
                S_SERVE: begin
                    w_load      = 1'b1;
                    w_last      = ((r_cnt + c_LEN_W'(1)) == r_len);
                    w_state_nxt = w_last ? S_READY : S_SERVE;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_tag         <= '0;
            r_out_valid   <= 1'b0;
            r_out_sos     <= 1'b0;
            r_out_eos     <= 1'b0;
            r_out_data    <= '0;
            r_fill_done   <= 1'b0;
            r_cache_valid <= 1'b0;
            r_err_abort   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_load;
            r_out_sos   <= w_accept;
            r_out_eos   <= w_load & w_last;
            r_out_data  <= w_load ? r_mem[w_rd_addr] : '0;
            r_fill_done <= w_fill_end;
            r_err_abort <= in_sos & (r_state == S_SERVE);
            if (in_sos) begin
                r_cache_valid <= in_eos;
            end else if (w_fill_end) begin
                r_cache_valid <= 1'b1;
            end
            if (w_accept) begin
                r_base <= w_req_base;
                r_len  <= w_req_len;
                r_tag  <= rd_tag;
                // Line 0 is loaded on the accept edge itself.
                r_cnt  <= c_LEN_W'(1);
            end else if (w_load) begin
                r_cnt  <= r_cnt + c_LEN_W'(1);
            end
        end
    end

    // Cache array: deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_mem[in_A] <= in_data;
        end
    end

    assign rd_req_ready = w_ready;
    assign out_valid    = r_out_valid;
    assign out_sos      = r_out_sos;
    assign out_eos      = r_out_eos;
    assign out_data     = r_out_data;
    assign out_tag      = r_tag;
    assign fill_done    = r_fill_done;
    assign cache_valid  = r_cache_valid;
    assign err_abort    = r_err_abort;

endmodule
`default_nettype wire

// File: tb/tb_sm_fv_bank_fill_serve.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm_fv_bank_fill_serve
// Purpose  : Self-checking bench for sm_fv_bank_fill_serve. A transaction
//            level model (line array + queue of pending burst beats) predicts
//            every output each cycle; directed tables and sequences add
//            hand-computed expectations for the corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_fv_bank_fill_serve;

    localparam int FV_BW  = 128;
    localparam int ADDR_W = 6;
    localparam int LPN    = 8;
    localparam int NODE_W = 3;
    localparam int TAG_W  = 2;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 64;

    logic               clk;
    logic               reset;
    logic               in_sos;
    logic               in_eos;
    logic [ADDR_W-1:0]  in_A;
    logic [FV_BW-1:0]   in_data;
    logic               rd_req_valid;
    logic               rd_req_ready;
    logic [NODE_W-1:0]  rd_node;
    logic [LEN_W-1:0]   rd_len;
    logic [TAG_W-1:0]   rd_tag;
    logic               out_valid;
    logic               out_sos;
    logic               out_eos;
    logic [FV_BW-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               fill_done;
    logic               cache_valid;
    logic               err_abort;

    sm_fv_bank_fill_serve #(
        .FV_BW(FV_BW), .ADDR_W(ADDR_W), .LINES_PER_NODE(LPN),
        .NODE_W(NODE_W), .PE_TAG_W(TAG_W)
    ) u_dut (
        .clk(clk), .reset(reset),
        .in_sos(in_sos), .in_eos(in_eos), .in_A(in_A), .in_data(in_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_node(rd_node), .rd_len(rd_len), .rd_tag(rd_tag),
        .out_valid(out_valid), .out_sos(out_sos), .out_eos(out_eos),
        .out_data(out_data), .out_tag(out_tag),
        .fill_done(fill_done), .cache_valid(cache_valid), .err_abort(err_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    typedef struct {
        int addr;
        bit sos;
        bit eos;
    } beat_t;

    logic [FV_BW-1:0]   m_mem [DEPTH];
    beat_t              m_q [$];
    bit                 m_filling = 1'b0;
    bit                 m_cv = 1'b0;
    logic [TAG_W-1:0]   m_tag = '0;
    logic               e_valid = 1'b0, e_sos = 1'b0, e_eos = 1'b0;
    logic [FV_BW-1:0]   e_data = '0;
    logic               e_done = 1'b0, e_abort = 1'b0;

    typedef struct {
        int node;
        int len;
        int tag;
        int first;
        int n;
    } req_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: check ready, advance model at the edge, compare outputs.
    task automatic tick();
        bit    ready_m;
        bit    acc;
        bit    wr;
        int    n;
        int    base;
        beat_t b;
        #1;
        ready_m = m_cv && (m_q.size() == 0) && !in_sos;
        chk("rd_req_ready", 128'(rd_req_ready), 128'(ready_m));
        acc = rd_req_valid && ready_m;
        @(posedge clk);
        if (!reset) begin
            m_filling = 1'b0;
            m_cv      = 1'b0;
            m_q.delete();
            m_tag     = '0;
            e_done    = 1'b0;
            e_abort   = 1'b0;
            e_valid   = 1'b0;
            e_sos     = 1'b0;
            e_eos     = 1'b0;
            e_data    = '0;
        end else begin
            wr      = in_sos || m_filling;
            e_abort = in_sos && (m_q.size() > 0);
            e_done  = 1'b0;
            if (in_sos) begin
                m_q.delete();
                m_filling = !in_eos;
                m_cv      = in_eos;
                e_done    = in_eos;
            end else if (m_filling && in_eos) begin
                m_filling = 1'b0;
                m_cv      = 1'b1;
                e_done    = 1'b1;
            end else if (acc) begin
                n    = (rd_len == 0 || int'(rd_len) > LPN) ? LPN : int'(rd_len);
                base = (int'(rd_node) * LPN) % DEPTH;
                for (int i = 0; i < n; i++)
                    m_q.push_back('{addr: (base + i) % DEPTH, sos: (i == 0), eos: (i == n - 1)});
                m_tag = rd_tag;
            end
            if (wr) m_mem[in_A] = in_data;
            if (m_q.size() > 0) begin
                b       = m_q.pop_front();
                e_valid = 1'b1;
                e_sos   = b.sos;
                e_eos   = b.eos;
                e_data  = m_mem[b.addr];
            end else begin
                e_valid = 1'b0;
                e_sos   = 1'b0;
                e_eos   = 1'b0;
                e_data  = '0;
            end
        end
        #1;
        chk("out_valid",   128'(out_valid),   128'(e_valid));
        chk("out_sos",     128'(out_sos),     128'(e_sos));
        chk("out_eos",     128'(out_eos),     128'(e_eos));
        chk("out_data",    out_data,          e_data);
        chk("out_tag",     128'(out_tag),     128'(m_tag));
        chk("fill_done",   128'(fill_done),   128'(e_done));
        chk("cache_valid", 128'(cache_valid), 128'(m_cv));
        chk("err_abort",   128'(err_abort),   128'(e_abort));
    endtask

    task automatic wait_ready();
        int k;
        for (k = 0; k < 20; k++) begin
            #1;
            if (rd_req_ready) break;
            tick();
        end
        checks++;
        if (k == 20) begin
            errors++;
            $display("FAIL wait_ready timeout actual=0 required=1");
        end
    endtask

    task automatic fill(input int lo, input int hi, input int dofs);
        for (int a = lo; a <= hi; a++) begin
            in_sos  = (a == lo);
            in_eos  = (a == hi);
            in_A    = ADDR_W'(a);
            in_data = FV_BW'(a + dofs);
            tick();
        end
        in_sos = 1'b0;
        in_eos = 1'b0;
        chk("fill_done_pulse",  128'(fill_done),    128'(1));
        chk("fill_cache_valid", 128'(cache_valid),  128'(1));
        chk("fill_ready",       128'(rd_req_ready), 128'(1));
    endtask

    task automatic req_check(input int node, input int len, input int tag,
                             input int first, input int n, input int dofs);
        rd_node      = NODE_W'(node);
        rd_len       = LEN_W'(len);
        rd_tag       = TAG_W'(tag);
        rd_req_valid = 1'b1;
        wait_ready();
        tick();
        rd_req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("burst_valid", 128'(out_valid), 128'(1));
            chk("burst_data",  out_data, 128'((first + i) % DEPTH + dofs));
            chk("burst_sos",   128'(out_sos), 128'(i == 0));
            chk("burst_eos",   128'(out_eos), 128'(i == n - 1));
            chk("burst_tag",   128'(out_tag), 128'(tag));
            tick();
        end
        chk("burst_end_valid", 128'(out_valid), 128'(0));
    endtask

    req_t tbl [5];
    logic [3:0] b2b_exp [5];

    initial begin
        tbl[0] = '{node: 1, len: 0, tag: 2, first: 8,  n: 8};
        tbl[1] = '{node: 7, len: 3, tag: 1, first: 56, n: 3};
        tbl[2] = '{node: 0, len: 1, tag: 0, first: 0,  n: 1};
        tbl[3] = '{node: 2, len: 9, tag: 3, first: 16, n: 8};
        tbl[4] = '{node: 5, len: 8, tag: 1, first: 40, n: 8};
        // {valid, sos, eos, tag[0]} per cycle for tags 0 then 3
        b2b_exp[0] = 4'b1100;
        b2b_exp[1] = 4'b1010;
        b2b_exp[2] = 4'b1101;
        b2b_exp[3] = 4'b1011;
        b2b_exp[4] = 4'b0001;

        reset = 1'b0; in_sos = 1'b0; in_eos = 1'b0; in_A = '0; in_data = '0;
        rd_req_valid = 1'b0; rd_node = '0; rd_len = '0; rd_tag = '0;
        tick();
        tick();
        chk("reset_out_valid",   128'(out_valid),   128'(0));
        chk("reset_cache_valid", 128'(cache_valid), 128'(0));
        chk("reset_out_tag",     128'(out_tag),     128'(0));
        reset = 1'b1;
        tick();
        chk("idle_ready", 128'(rd_req_ready), 128'(0));

        // Short fill then node 1 read of lines 8..15
        fill(0, 15, 'h100);
        tick();
        chk("fill_done_once", 128'(fill_done), 128'(0));
        req_check(1, 0, 2, 8, 8, 'h100);

        // Full fill then directed request table
        fill(0, 63, 'h100);
        for (int t = 0; t < 5; t++)
            req_check(tbl[t].node, tbl[t].len, tbl[t].tag, tbl[t].first, tbl[t].n, 'h100);

        // Back-to-back requests held valid: tags 0 then 3
        rd_node = 3'd2; rd_len = 4'd2; rd_tag = 2'd0; rd_req_valid = 1'b1;
        wait_ready();
        tick();
        rd_node = 3'd3; rd_tag = 2'd3;
        for (int c = 0; c < 5; c++) begin
            chk("b2b_valid", 128'(out_valid), 128'(b2b_exp[c][3]));
            chk("b2b_sos",   128'(out_sos),   128'(b2b_exp[c][2]));
            chk("b2b_eos",   128'(out_eos),   128'(b2b_exp[c][1]));
            chk("b2b_tag",   128'(out_tag),   128'(b2b_exp[c][0] ? 3 : 0));
            if (c == 2) rd_req_valid = 1'b0;
            tick();
        end

        // Abort at burst beat 3
        rd_node = 3'd4; rd_len = 4'd0; rd_tag = 2'd1; rd_req_valid = 1'b1;
        wait_ready();
        tick();
        rd_req_valid = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_data", out_data, 128'('h100 + 35));
        in_sos = 1'b1; in_A = '0; in_data = 128'('h200);
        tick();
        in_sos = 1'b0;
        chk("abort_valid", 128'(out_valid),   128'(0));
        chk("abort_eos",   128'(out_eos),     128'(0));
        chk("abort_err",   128'(err_abort),   128'(1));
        chk("abort_cv",    128'(cache_valid), 128'(0));
        for (int a = 1; a <= 7; a++) begin
            in_A = ADDR_W'(a); in_data = FV_BW'(a + 'h200); in_eos = (a == 7);
            tick();
            if (a == 1) chk("abort_err_once", 128'(err_abort), 128'(0));
        end
        in_eos = 1'b0;
        chk("refill_done", 128'(fill_done), 128'(1));
        req_check(0, 8, 0, 0, 8, 'h200);

        // Reset in the middle of a fill
        for (int a = 0; a < 4; a++) begin
            in_sos = (a == 0); in_A = ADDR_W'(a); in_data = FV_BW'(a + 'h300);
            tick();
        end
        in_sos = 1'b0;
        reset = 1'b0;
        tick();
        chk("rst_fill_cv",   128'(cache_valid), 128'(0));
        chk("rst_fill_done", 128'(fill_done),   128'(0));
        chk("rst_fill_out",  128'(out_valid),   128'(0));
        reset = 1'b1;
        rd_node = '0; rd_len = 4'd1; rd_tag = 2'd2; rd_req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("held_off_ready", 128'(rd_req_ready), 128'(0));
            tick();
            chk("held_off_out", 128'(out_valid), 128'(0));
        end
        fill(0, 63, 'h400);
        wait_ready();
        tick();
        rd_req_valid = 1'b0;
        chk("post_rst_sos",  128'(out_sos),  128'(1));
        chk("post_rst_eos",  128'(out_eos),  128'(1));
        chk("post_rst_data", out_data,       128'('h400));
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 199) != 0);
            in_sos       = ($urandom_range(0, 19) == 0);
            in_eos       = ($urandom_range(0, 5) == 0);
            in_A         = ADDR_W'($urandom);
            in_data      = {$urandom, $urandom, $urandom, $urandom};
            rd_req_valid = 1'($urandom_range(0, 1));
            rd_node      = NODE_W'($urandom);
            rd_len       = LEN_W'($urandom);
            rd_tag       = TAG_W'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sm_fv_bank_fill_serve.md
Name: sm_fv_bank_fill_serve

Overview:
- Small feature-value bank that sits directly downstream of the big FV bank controller.
- Captures one replay iteration's FV stream (sos/eos framed, addressed lines) into a local register-array cache.
- Then serves per-node multi-line reads to Edge PEs as sos/eos framed bursts tagged with the requesting PE.
- One fill and one serve can never overlap; the stream has priority.

Parameters:
FV_BW, 128, width of one FV cache line
ADDR_W, 6, line address width; DEPTH = 2**ADDR_W lines
LINES_PER_NODE, 8, lines per node (power of two)
NODE_W, 3, node index width
PE_TAG_W, 2, Edge PE tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
in_sos  in  1  first beat of stream
in_eos  in  1  last beat of stream
in_A  in  ADDR_W  line address of current beat
in_data  in  FV_BW  line data of current beat
rd_req_valid  in  1  Edge PE read request
rd_req_ready  out  1  request accepted this cycle when high with valid
rd_node  in  NODE_W  node index to read
rd_len  in  $clog2(LINES_PER_NODE)+1  lines to return; 0 means LINES_PER_NODE
rd_tag  in  PE_TAG_W  requester tag
out_valid  out  1  output beat valid
out_sos  out  1  first output beat
out_eos  out  1  last output beat
out_data  out  FV_BW  output line
out_tag  out  PE_TAG_W  tag of burst
fill_done  out  1  one-cycle pulse after eos beat written
cache_valid  out  1  cache holds a complete iteration
err_abort  out  1  one-cycle pulse when a serve is aborted by a new stream

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; all outputs 0; cache_valid=0; counters and tag registers 0. Array contents are not reset.
- States:
  - IDLE: cache empty.
  - FILL: capturing stream.
  - READY: cache valid, waiting for a request.
  - SERVE: emitting a burst.
- Beat definition: a beat is written when in_sos=1 (any state) or state==FILL; write mem[in_A] <= in_data at posedge.
- IDLE/READY + in_sos -> FILL; cache_valid <= 0.
- Single-beat stream (in_sos & in_eos in the same cycle): write that beat, go to READY, pulse fill_done.
- FILL + in_eos -> READY next cycle; fill_done=1 for exactly that cycle; cache_valid <= 1.
- FILL + in_sos again: restart the fill; the beat is still written; no error.
- SERVE + in_sos:
  - Abort the burst; the beat is written; go to FILL.
  - Next cycle: out_valid=0, no out_eos issued, err_abort=1 for one cycle.
- rd_req_ready = (state==READY) & ~in_sos (combinational).
- Request acceptance (rd_req_valid & rd_req_ready) latches:
  - base = rd_node * LINES_PER_NODE (shift)
  - len = (rd_len==0) ? LINES_PER_NODE : min(rd_len, LINES_PER_NODE)
  - tag = rd_tag
  - line counter = 0
  - next state SERVE
- SERVE output timing:
  - Registered outputs; first beat appears the cycle after acceptance (latency 1).
  - Beat i: out_data = mem[(base+i) mod DEPTH], out_valid=1, out_tag = latched tag.
  - out_sos=1 on i==0; out_eos=1 on i==len-1; both high if len==1.
  - One beat per cycle, no backpressure.
  - After the eos beat: state READY; out_valid=0 the following cycle.
  - Back-to-back requests: the earliest next acceptance is the cycle the eos beat is on the outputs. The next burst's sos then follows eos with no gap.
- Arithmetic: address add is ADDR_W bits and wraps modulo DEPTH. rd_node values beyond DEPTH/LINES_PER_NODE alias by wrap.
- Write/read same line in the same cycle is impossible by state exclusion. A beat written in the cycle an abort happens is not read.
- Reset mid-FILL or mid-SERVE: immediate return to IDLE, outputs 0, no eos, no fill_done.
- Requests in IDLE/FILL/SERVE are held off (ready=0); the requester keeps valid asserted.

Test Plan:
- Fill beats A=0..15 with data=A+0x100, sos at A=0, eos at A=15 -> fill_done pulses once on the cycle after the eos beat; cache_valid=1; rd_req_ready=1.
- After fill, request node=1, len=0, tag=2 -> 8 beats starting next cycle, data 0x108..0x10F, sos on beat 0, eos on beat 7, out_tag=2.
- Request node=7 with DEPTH=64 after full fill of A=0..63, len=3 -> lines 56,57,58; request node=0, len=1 -> single beat with sos=eos=1.
- Two requests held valid back-to-back (tags 0 then 3) -> second burst's sos immediately follows first burst's eos, with no idle cycle.
- in_sos arrives at burst beat 3 -> out_valid=0 next cycle, no eos, err_abort=1 one cycle; new fill completes normally.
- reset deasserted-low mid-FILL -> all outputs 0; cache_valid=0; a rd_req_valid afterwards is not accepted until a new fill completes.
